ex_operand_stage: RTL and testbench
===================================

// Module: ex_operand_stage
// PURPOSE
//  ID/EX pipeline register and operand-select stage of the 16-bit pipelined CPU.
//  Accepts decoded instructions from decode and presents alu_op/operand_a/operand_b to the ALU.
//  Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, or by stalling, and applies stall/flush.
// PARAMETERS
//  DATA_W       16  datapath width
//  REG_AW       3   register address width (8 regs, r0 reads 0)
//  OP_W         4   alu_op width
//  STALL_CNT_W  16  stall counter width
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        async active-low reset
//  id_valid     in   1        decode holds a valid instruction
//  id_ready     out  1        stage accepts it this cycle
//  id_alu_op    in   OP_W     ALU opcode (cpu_pkg codes)
//  id_rs1/2     in   REG_AW   source register indices
//  id_rs1/2_data in  DATA_W   register-file read data
//  id_imm       in   DATA_W   sign-extended immediate
//  id_use_imm   in   1        operand_b = imm instead of rs2
//  id_rd        in   REG_AW   destination index
//  id_wr_en     in   1        instruction writes rd
//  flush        in   1        kill stage contents (branch redirect)
//  ex_ready     in   1        execute consumes stage this cycle
//  ex_valid     out  1        stage holds a valid instruction
//  ex_alu_op    out  OP_W     to ALU alu_op
//  ex_operand_a out  DATA_W   to ALU operand_a
//  ex_operand_b out  DATA_W   to ALU operand_b
//  ex_rd/ex_wr_en out REG_AW/1 destination passed down
//  mem_wr_en/mem_rd/mem_result in 1/REG_AW/DATA_W  EX/MEM writer
//  wb_wr_en/wb_rd/wb_result    in 1/REG_AW/DATA_W  MEM/WB writer (same as RF write port)
//  stall_count  out  STALL_CNT_W  cycles with id_valid && !id_ready
// BEHAVIOUR
//  - Reset: ex_valid=0, all latched fields 0, stall_count=0; outputs driven from regs -> all 0.
//  - Load when id_valid && id_ready: latch op, rs, rs data, imm, use_imm, rd, wr_en; ex_valid<=1.
//  - Else if ex_ready && ex_valid: ex_valid<=0 (bubble). Else hold.
//  - id_ready = !flush && (!ex_valid || ex_ready) && !hazard_stall.
//  - flush: ex_valid<=0 next edge, overrides load and hold; concurrent id transfer refused.
//  - Snoop: every cycle, if wb_wr_en && wb_rd!=0 && wb_rd==latched rs1/rs2, latched data<=wb_result
//    (keeps held operands current across stalls).
//  - Forward (comb, output side): src = rs==0 ? 0 : mem match ? mem_result : wb match ? wb_result
//    : latched data; match = wr_en && rd==rs && rd!=0. MEM beats WB.
//  - operand_a = fwd(rs1); b_raw = use_imm ? imm : fwd(rs2).
//  - alu_op==SUB: operand_b = ~b_raw+1 (mod 2^16; 0x8000 -> 0x8000) so ALU adder yields a-b.
//  - ex_alu_op/ex_rd/ex_wr_en straight from regs; operands valid only while ex_valid.
//  - stall_count: +1 per cycle id_valid && !id_ready, saturates at all-ones; never wraps.
// CONFIGURATION
//  FWD_EN defined: forwarding as above; hazard_stall=0.
//  FWD_EN undefined: no MEM/WB forwarding muxes (snoop kept); hazard_stall=1 when id_valid and an
//    id rs (nonzero, rs2 only if !id_use_imm) equals this stage's rd (ex_valid&&ex_wr_en) or
//    mem_rd (mem_wr_en). WB needs no stall (write-first RF + snoop).
// STRUCTURE
//  cpu_pkg: ALU opcode constants (ADD,SUB,AND,OR,XOR), DATA_W/REG_AW/OP_W defaults.
//  Sub-module fwd_sel: one source-operand forward mux, instantiated twice.
// TESTING
//  1 FWD_EN: I1 rd=1 in MEM, mem_result=0x0005; I2 rs1=1 -> ex_operand_a=0x0005.
//  2 mem and wb both rd=2 (0x1111/0x2222), rs2=2, use_imm=0 -> ex_operand_b=0x1111.
//  3 SUB b=0x0003 -> operand_b=0xFFFD; b=0x8000 -> 0x8000; ADD b=0x0003 -> 0x0003.
//  4 ex_ready=0 3 cycles, wb writes rs1 0x00AA mid-hold -> id_ready=0, fields hold, operand_a=0x00AA
//    after wb clears; stall_count=3.
//  5 flush with id_valid=1 -> id_ready=0, ex_valid=0 next cycle, instruction not taken.
//  6 no FWD_EN: mem_rd=3 mem_wr_en, id_rs1=3 -> id_ready=0 until mem clears; rs1=0 never stalls;
//    rst_n low mid-stall -> ex_valid=0, stall_count=0 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the 16-bit pipelined CPU.
//   - Default datapath / register-address / opcode / counter widths.
//   - ALU opcode codes used by decode, the operand stage and the ALU.
// No ports; imported with "import cpu_pkg::*;".
package cpu_pkg;

  localparam int CPU_DATA_W      = 16;
  localparam int CPU_REG_AW      = 3;
  localparam int CPU_OP_W        = 4;
  localparam int CPU_STALL_CNT_W = 16;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4
  } alu_op_e;

  localparam logic [3:0] OP_ADD = 4'(ALU_ADD);
  localparam logic [3:0] OP_SUB = 4'(ALU_SUB);
  localparam logic [3:0] OP_AND = 4'(ALU_AND);
  localparam logic [3:0] OP_OR  = 4'(ALU_OR);
  localparam logic [3:0] OP_XOR = 4'(ALU_XOR);

endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: source-operand select for one ALU operand.
//   Picks the value of register 'rs' as seen by the instruction sitting in EX:
//   r0 reads 0; with FWD_EN defined the EX/MEM writer wins over the MEM/WB
//   writer, which wins over the data latched (and snooped) in the stage.
//   Without FWD_EN only the r0 rule and the latched data are used.
// Configuration macro: FWD_EN.
// Ports:
//   rs                          register index of this operand
//   held_data                   data latched in the ID/EX register
//   mem_wr_en/mem_rd/mem_result EX/MEM writer
//   wb_wr_en/wb_rd/wb_result    MEM/WB writer
//   data                        selected operand value
module fwd_sel
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int REG_AW = CPU_REG_AW
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [DATA_W-1:0] held_data,
  input  logic              mem_wr_en,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_wr_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] data
);

`ifdef FWD_EN
  logic mem_hit;
  logic wb_hit;

  always_comb begin
    mem_hit = mem_wr_en && (mem_rd == rs) && (mem_rd != '0);
    wb_hit  = wb_wr_en  && (wb_rd  == rs) && (wb_rd  != '0);
    data    = held_data;
    if (rs == '0)   data = '0;
    else if (mem_hit) data = mem_result;
    else if (wb_hit)  data = wb_result;
  end
`else
  // Writers are resolved by stalling and snooping elsewhere; their buses
  // are not needed here.
  logic unused_fwd;
  assign unused_fwd = ^{mem_wr_en, mem_rd, mem_result, wb_wr_en, wb_rd, wb_result};

  always_comb begin
    data = held_data;
    if (rs == '0) data = '0;
  end
`endif

endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register and ALU operand select.
//   Latches decoded instructions, keeps held source data current by snooping
//   the MEM/WB writer, forwards from EX/MEM and MEM/WB (FWD_EN) or stalls on
//   RAW hazards (FWD_EN undefined), negates operand_b for SUB, and counts
//   decode stall cycles.
// Configuration macro: FWD_EN (defined = forwarding, undefined = interlock).
// Ports:
//   clk, rst_n                     clock (rising edge), async active-low reset
//   id_valid/id_ready              decode -> stage handshake
//   id_alu_op, id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_imm,
//   id_use_imm, id_rd, id_wr_en    decoded instruction fields
//   flush                          kill stage contents (branch redirect)
//   ex_ready/ex_valid              stage -> execute handshake
//   ex_alu_op, ex_operand_a, ex_operand_b, ex_rd, ex_wr_en   to ALU / down the pipe
//   mem_wr_en/mem_rd/mem_result    EX/MEM writer
//   wb_wr_en/wb_rd/wb_result       MEM/WB writer (register-file write port)
//   stall_count                    saturating count of id_valid && !id_ready cycles
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The sender holds its payload stable while valid is high and ready is
// low; ready never depends on the receiver's own valid being accepted first.
module ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W      = CPU_DATA_W,
  parameter int REG_AW      = CPU_REG_AW,
  parameter int OP_W        = CPU_OP_W,
  parameter int STALL_CNT_W = CPU_STALL_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  output logic                   id_ready,
  input  logic [OP_W-1:0]        id_alu_op,
  input  logic [REG_AW-1:0]      id_rs1,
  input  logic [REG_AW-1:0]      id_rs2,
  input  logic [DATA_W-1:0]      id_rs1_data,
  input  logic [DATA_W-1:0]      id_rs2_data,
  input  logic [DATA_W-1:0]      id_imm,
  input  logic                   id_use_imm,
  input  logic [REG_AW-1:0]      id_rd,
  input  logic                   id_wr_en,
  input  logic                   flush,
  input  logic                   ex_ready,
  output logic                   ex_valid,
  output logic [OP_W-1:0]        ex_alu_op,
  output logic [DATA_W-1:0]      ex_operand_a,
  output logic [DATA_W-1:0]      ex_operand_b,
  output logic [REG_AW-1:0]      ex_rd,
  output logic                   ex_wr_en,
  input  logic                   mem_wr_en,
  input  logic [REG_AW-1:0]      mem_rd,
  input  logic [DATA_W-1:0]      mem_result,
  input  logic                   wb_wr_en,
  input  logic [REG_AW-1:0]      wb_rd,
  input  logic [DATA_W-1:0]      wb_result,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic                   valid_q;
  logic [OP_W-1:0]        op_q;
  logic [REG_AW-1:0]      rs1_q;
  logic [REG_AW-1:0]      rs2_q;
  logic [DATA_W-1:0]      rs1_data_q;
  logic [DATA_W-1:0]      rs2_data_q;
  logic [DATA_W-1:0]      imm_q;
  logic                   use_imm_q;
  logic [REG_AW-1:0]      rd_q;
  logic                   wr_en_q;
  logic [STALL_CNT_W-1:0] stall_q;

  logic                   hazard_stall;
  logic                   load;
  logic [DATA_W-1:0]      src_a;
  logic [DATA_W-1:0]      src_b;
  logic [DATA_W-1:0]      b_raw;

  // ---------------------------------------------------------------- hazards
`ifdef FWD_EN
  assign hazard_stall = 1'b0;
`else
  logic rs1_hit;
  logic rs2_hit;

  // A producer still in EX or MEM has not reached the register file yet.
  // WB needs no stall: the register file is write-first and held data is
  // snooped.
  always_comb begin
    rs1_hit = (id_rs1 != '0) &&
              ((valid_q && wr_en_q && (id_rs1 == rd_q)) ||
               (mem_wr_en && (id_rs1 == mem_rd)));
    rs2_hit = !id_use_imm && (id_rs2 != '0) &&
              ((valid_q && wr_en_q && (id_rs2 == rd_q)) ||
               (mem_wr_en && (id_rs2 == mem_rd)));
    hazard_stall = id_valid && (rs1_hit || rs2_hit);
  end
`endif

  assign id_ready = !flush && (!valid_q || ex_ready) && !hazard_stall;
  assign load     = id_valid && id_ready;

  // ------------------------------------------------------- pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      op_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      use_imm_q  <= 1'b0;
      rd_q       <= '0;
      wr_en_q    <= 1'b0;
    end else begin
      if (flush)                   valid_q <= 1'b0;
      else if (load)               valid_q <= 1'b1;
      else if (ex_ready && valid_q) valid_q <= 1'b0;

      if (load) begin
        op_q       <= id_alu_op;
        rs1_q      <= id_rs1;
        rs2_q      <= id_rs2;
        rs1_data_q <= id_rs1_data;
        rs2_data_q <= id_rs2_data;
        imm_q      <= id_imm;
        use_imm_q  <= id_use_imm;
        rd_q       <= id_rd;
        wr_en_q    <= id_wr_en;
      end else begin
        // Snoop the register-file write so a held instruction never goes stale.
        if (wb_wr_en && (wb_rd != '0) && (wb_rd == rs1_q)) rs1_data_q <= wb_result;
        if (wb_wr_en && (wb_rd != '0) && (wb_rd == rs2_q)) rs2_data_q <= wb_result;
      end
    end
  end

  // ------------------------------------------------------------ stall count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (id_valid && !id_ready && (stall_q != '1)) begin
      stall_q <= stall_q + STALL_CNT_W'(1);
    end
  end

  // ---------------------------------------------------------- operand select
  fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
    .rs         (rs1_q),
    .held_data  (rs1_data_q),
    .mem_wr_en  (mem_wr_en),
    .mem_rd     (mem_rd),
    .mem_result (mem_result),
    .wb_wr_en   (wb_wr_en),
    .wb_rd      (wb_rd),
    .wb_result  (wb_result),
    .data       (src_a)
  );

  fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
    .rs         (rs2_q),
    .held_data  (rs2_data_q),
    .mem_wr_en  (mem_wr_en),
    .mem_rd     (mem_rd),
    .mem_result (mem_result),
    .wb_wr_en   (wb_wr_en),
    .wb_rd      (wb_rd),
    .wb_result  (wb_result),
    .data       (src_b)
  );

  assign b_raw = use_imm_q ? imm_q : src_b;

  // SUB reuses the ALU adder: present the two's complement of b.
  always_comb begin
    ex_operand_b = b_raw;
    if (op_q == OP_W'(OP_SUB)) ex_operand_b = ~b_raw + DATA_W'(1);
  end

  assign ex_operand_a = src_a;
  assign ex_valid     = valid_q;
  assign ex_alu_op    = op_q;
  assign ex_rd        = rd_q;
  assign ex_wr_en     = wr_en_q;
  assign stall_count  = stall_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: vector table for operand selection,
// hand-written sequences for hold/snoop, flush, hazards and reset.
// Builds with or without FWD_EN.
module tb_ex_operand_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic        id_ready;
  logic [3:0]  id_alu_op;
  logic [2:0]  id_rs1, id_rs2;
  logic [15:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_use_imm;
  logic [2:0]  id_rd;
  logic        id_wr_en;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [3:0]  ex_alu_op;
  logic [15:0] ex_operand_a, ex_operand_b;
  logic [2:0]  ex_rd;
  logic        ex_wr_en;
  logic        mem_wr_en;
  logic [2:0]  mem_rd;
  logic [15:0] mem_result;
  logic        wb_wr_en;
  logic [2:0]  wb_rd;
  logic [15:0] wb_result;
  logic [15:0] stall_count;

  int checks = 0;
  int fails  = 0;
  int exp_stall = 0;
  logic [31:0] exp_q[$];

  ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_alu_op(id_alu_op), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_alu_op(ex_alu_op), .ex_operand_a(ex_operand_a), .ex_operand_b(ex_operand_b),
    .ex_rd(ex_rd), .ex_wr_en(ex_wr_en),
    .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_result(wb_result),
    .stall_count(stall_count)
  );

  // ---------------------------------------------------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------- helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_id(input logic [3:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                          input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] imm,
                          input logic use_imm, input logic [2:0] rd, input logic wr_en);
    id_alu_op   = op;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rs1_data = d1;
    id_rs2_data = d2;
    id_imm      = imm;
    id_use_imm  = use_imm;
    id_rd       = rd;
    id_wr_en    = wr_en;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  rs1, rs2;
    logic [15:0] d1, d2, imm;
    logic        use_imm;
    logic [2:0]  rd;
    logic        wr_en;
    logic [15:0] exp_a, exp_b;
  } vec_t;

  vec_t vecs[9];

  // ------------------------------------------------------------------ test
  initial begin
    logic [31:0] exp_ab;

    //            op     rs1   rs2   d1        d2        imm       ui    rd    we    exp_a     exp_b
    vecs[0] = '{4'd0, 3'd1, 3'd2, 16'h1234, 16'h0003, 16'h0000, 1'b0, 3'd3, 1'b1, 16'h1234, 16'h0003};
    vecs[1] = '{4'd1, 3'd1, 3'd2, 16'h0010, 16'h0003, 16'h0000, 1'b0, 3'd3, 1'b1, 16'h0010, 16'hFFFD};
    vecs[2] = '{4'd1, 3'd3, 3'd4, 16'h7FFF, 16'h8000, 16'h0000, 1'b0, 3'd5, 1'b1, 16'h7FFF, 16'h8000};
    vecs[3] = '{4'd1, 3'd5, 3'd6, 16'h0001, 16'h9999, 16'h0001, 1'b1, 3'd6, 1'b1, 16'h0001, 16'hFFFF};
    vecs[4] = '{4'd0, 3'd0, 3'd0, 16'hBEEF, 16'h5555, 16'h0000, 1'b0, 3'd7, 1'b1, 16'h0000, 16'h0000};
    vecs[5] = '{4'd4, 3'd7, 3'd0, 16'hFFFF, 16'h1234, 16'h00F0, 1'b1, 3'd1, 1'b0, 16'hFFFF, 16'h00F0};
    vecs[6] = '{4'd1, 3'd2, 3'd0, 16'h0042, 16'h7777, 16'h0000, 1'b0, 3'd2, 1'b1, 16'h0042, 16'h0000};
    vecs[7] = '{4'd2, 3'd5, 3'd6, 16'h0F0F, 16'hF0F0, 16'h0000, 1'b0, 3'd4, 1'b0, 16'h0F0F, 16'hF0F0};
    vecs[8] = '{4'd3, 3'd6, 3'd3, 16'h1111, 16'h2222, 16'h8000, 1'b1, 3'd0, 1'b1, 16'h1111, 16'h8000};

    rst_n = 1'b0;
    id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b0;
    drive_id(4'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 1'b0);
    mem_wr_en = 1'b0; mem_rd = 3'd0; mem_result = 16'h0;
    wb_wr_en = 1'b0;  wb_rd = 3'd0;  wb_result = 16'h0;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_operand_a", 32'(ex_operand_a), 32'h0);
    check("rst_operand_b", 32'(ex_operand_b), 32'h0);
    check("rst_alu_op", 32'(ex_alu_op), 32'h0);
    check("rst_rd_wr_en", {28'h0, ex_rd, ex_wr_en}, 32'h0);
    check("rst_stall_count", 32'(stall_count), 32'h0);
    rst_n = 1'b1;
    ex_ready = 1'b1;
    @(negedge clk);
    check("idle_id_ready", 32'(id_ready), 32'd1);

    // Vector table: load, then inspect the stage in the following cycle
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive_id(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].d1, vecs[i].d2,
               vecs[i].imm, vecs[i].use_imm, vecs[i].rd, vecs[i].wr_en);
      id_valid = 1'b1;
      exp_q.push_back({vecs[i].exp_a, vecs[i].exp_b});
      @(negedge clk);
      id_valid = 1'b0;
      #1;
      exp_ab = exp_q.pop_front();
      check($sformatf("vec%0d_ex_valid", i), 32'(ex_valid), 32'd1);
      check($sformatf("vec%0d_operand_a", i), 32'(ex_operand_a), 32'(exp_ab[31:16]));
      check($sformatf("vec%0d_operand_b", i), 32'(ex_operand_b), 32'(exp_ab[15:0]));
      check($sformatf("vec%0d_alu_op", i), 32'(ex_alu_op), 32'(vecs[i].op));
      check($sformatf("vec%0d_rd", i), 32'(ex_rd), 32'(vecs[i].rd));
      check($sformatf("vec%0d_wr_en", i), 32'(ex_wr_en), 32'(vecs[i].wr_en));
    end
    @(negedge clk);
    check("table_ex_drained", 32'(ex_valid), 32'd0);
    check("table_stall_count", 32'(stall_count), 32'(exp_stall));

    // Hold with ex_ready low; WB writes rs1 while held
    drive_id(4'd0, 3'd1, 3'd2, 16'h0011, 16'h0022, 16'h0, 1'b0, 3'd4, 1'b1);
    id_valid = 1'b1; ex_ready = 1'b0;
    @(negedge clk);
    drive_id(4'd0, 3'd2, 3'd3, 16'h0101, 16'h0202, 16'h0303, 1'b1, 3'd5, 1'b0);
    #1;
    check("hold_id_ready0", 32'(id_ready), 32'd0);
    @(negedge clk);
    exp_stall++;
    wb_wr_en = 1'b1; wb_rd = 3'd1; wb_result = 16'h00AA;
    #1;
    check("hold_rd", 32'(ex_rd), 32'd4);
    @(negedge clk);
    exp_stall++;
    wb_wr_en = 1'b0; wb_rd = 3'd0; wb_result = 16'h0;
    #1;
    check("hold_snoop_a", 32'(ex_operand_a), 32'h00AA);
    check("hold_operand_b", 32'(ex_operand_b), 32'h0022);
    check("hold_id_ready1", 32'(id_ready), 32'd0);
    @(negedge clk);
    exp_stall++;
    id_valid = 1'b0;
    #1;
    check("hold_stall_count", 32'(stall_count), 32'(exp_stall));
    check("hold_ex_valid", 32'(ex_valid), 32'd1);
    check("hold_snoop_a_kept", 32'(ex_operand_a), 32'h00AA);
    check("hold_wr_en", 32'(ex_wr_en), 32'd1);
    ex_ready = 1'b1;
    @(negedge clk);
    check("hold_released", 32'(ex_valid), 32'd0);

    // Flush against a held instruction with decode offering another
    drive_id(4'd2, 3'd1, 3'd0, 16'h0C0C, 16'h0, 16'h0, 1'b0, 3'd2, 1'b0);
    id_valid = 1'b1; ex_ready = 1'b0;
    @(negedge clk);
    drive_id(4'd3, 3'd1, 3'd1, 16'h0D0D, 16'h0, 16'h0, 1'b1, 3'd7, 1'b1);
    flush = 1'b1;
    #1;
    check("flush_id_ready", 32'(id_ready), 32'd0);
    @(negedge clk);
    exp_stall++;
    flush = 1'b0; id_valid = 1'b0;
    #1;
    check("flush_ex_valid", 32'(ex_valid), 32'd0);
    check("flush_not_taken_rd", 32'(ex_rd), 32'd2);
    check("flush_not_taken_op", 32'(ex_alu_op), 32'd2);
    check("flush_stall_count", 32'(stall_count), 32'(exp_stall));
    ex_ready = 1'b1;
    @(negedge clk);

`ifdef FWD_EN
    // Forwarding: MEM, MEM over WB, WB alone; no stall on a MEM match
    drive_id(4'd0, 3'd1, 3'd2, 16'h9999, 16'h7777, 16'h0, 1'b0, 3'd3, 1'b1);
    id_valid = 1'b1;
    mem_wr_en = 1'b1; mem_rd = 3'd1; mem_result = 16'h0005;
    #1;
    check("fwd_no_stall", 32'(id_ready), 32'd1);
    @(negedge clk);
    id_valid = 1'b0;
    #1;
    check("fwd_mem_a", 32'(ex_operand_a), 32'h0005);
    mem_rd = 3'd2; mem_result = 16'h1111;
    wb_wr_en = 1'b1; wb_rd = 3'd2; wb_result = 16'h2222;
    #1;
    check("fwd_mem_beats_wb", 32'(ex_operand_b), 32'h1111);
    check("fwd_a_unmatched", 32'(ex_operand_a), 32'h9999);
    mem_wr_en = 1'b0;
    #1;
    check("fwd_wb_b", 32'(ex_operand_b), 32'h2222);
    wb_wr_en = 1'b0; wb_rd = 3'd0; wb_result = 16'h0;
    mem_rd = 3'd0; mem_result = 16'h0;
    @(negedge clk);
`else
    // Interlock: MEM producer stalls until it clears
    mem_wr_en = 1'b1; mem_rd = 3'd3; mem_result = 16'h0;
    drive_id(4'd0, 3'd3, 3'd1, 16'h0033, 16'h0, 16'h0044, 1'b1, 3'd1, 1'b1);
    id_valid = 1'b1;
    #1;
    check("haz_mem_stall", 32'(id_ready), 32'd0);
    @(negedge clk);
    exp_stall++;
    #1;
    check("haz_mem_still", 32'(id_ready), 32'd0);
    check("haz_not_loaded", 32'(ex_valid), 32'd0);
    mem_wr_en = 1'b0;
    #1;
    check("haz_mem_cleared", 32'(id_ready), 32'd1);
    @(negedge clk);
    check("haz_loaded", 32'(ex_valid), 32'd1);
    check("haz_loaded_a", 32'(ex_operand_a), 32'h0033);
    // EX producer (rd=1, wr_en) against a new consumer of r1
    drive_id(4'd0, 3'd1, 3'd0, 16'h0, 16'h0, 16'h0, 1'b1, 3'd2, 1'b0);
    #1;
    check("haz_ex_stall", 32'(id_ready), 32'd0);
    @(negedge clk);
    exp_stall++;
    #1;
    check("haz_ex_cleared", 32'(id_ready), 32'd1);
    id_valid = 1'b0;
    @(negedge clk);
    // r0 and immediate operands never stall
    mem_wr_en = 1'b1; mem_rd = 3'd5;
    drive_id(4'd0, 3'd0, 3'd5, 16'h0, 16'h0, 16'h0, 1'b1, 3'd2, 1'b0);
    id_valid = 1'b1;
    #1;
    check("haz_imm_no_stall", 32'(id_ready), 32'd1);
    id_use_imm = 1'b0;
    #1;
    check("haz_rs2_stall", 32'(id_ready), 32'd0);
    mem_rd = 3'd0; id_rs2 = 3'd0;
    #1;
    check("haz_r0_no_stall", 32'(id_ready), 32'd1);
    id_valid = 1'b0; mem_wr_en = 1'b0;
    @(negedge clk);
`endif

    // Reset in the middle of a stall
    drive_id(4'd1, 3'd2, 3'd0, 16'h00F0, 16'h0, 16'h0001, 1'b1, 3'd1, 1'b1);
    id_valid = 1'b1; ex_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp_stall++;
    @(negedge clk);
    exp_stall++;
    check("pre_reset_stall_count", 32'(stall_count), 32'(exp_stall));
    check("pre_reset_ex_valid", 32'(ex_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_ex_valid", 32'(ex_valid), 32'd0);
    check("mid_reset_stall_count", 32'(stall_count), 32'h0);
    check("mid_reset_rd", 32'(ex_rd), 32'd0);
    @(negedge clk);
    id_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
